// File: rtl/fir_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// fir_ctrl_fsm
//   Job sequencer for fir_datapath. An accepted start latches the job length
//   and output shift, pulses clear, loads NB_TAPS coefficients over the tap
//   handshake, then gates the x stream for len samples and counts y results
//   until len of them have left the datapath. It reports busy/done.
//
//   Handshake rule (h, x and y): a transfer happens on a rising clk_i edge
//   where valid and ready are both high. valid must not depend on ready.
//   x and y are only monitored here; this block never drives their valid or
//   ready.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        job start request, sampled only in IDLE
//   abort_i        abort the current job (ignored in IDLE, blocks a start there)
//   len_i          samples per job, latched on accepted start
//   right_shift_i  output shift, latched on accepted start
//   h_valid_i      coefficient source valid
//   h_ready_o      coefficient sink ready, high only in LOAD_H
//   x_gate_o       enables the x source while fewer than len x transfers seen
//   x_valid_i      x handshake monitor, valid at datapath input
//   x_ready_i      x handshake monitor, ready at datapath input
//   y_valid_i      y handshake monitor, valid at datapath output
//   y_ready_i      y handshake monitor, ready at datapath output
//   clear_o        one-cycle clear to datapath/streamers
//   right_shift_o  registered right_shift for the datapath
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse on successful job completion
//   dbg_state_o    current FSM state encoding (debug/observability)
// -----------------------------------------------------------------------------
module fir_ctrl_fsm #(
  parameter int unsigned NB_TAPS = 50,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [SHIFT_W-1:0] right_shift_i,
  input  logic               h_valid_i,
  output logic               h_ready_o,
  output logic               x_gate_o,
  input  logic               x_valid_i,
  input  logic               x_ready_i,
  input  logic               y_valid_i,
  input  logic               y_ready_i,
  output logic               clear_o,
  output logic [SHIFT_W-1:0] right_shift_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         dbg_state_o
);

  localparam int unsigned H_W = $clog2(NB_TAPS + 1);
  localparam logic [H_W-1:0] H_LAST = H_W'(NB_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_H = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [H_W-1:0]     h_cnt_q, h_cnt_d;
  logic [LEN_W-1:0]   x_cnt_q, x_cnt_d;
  logic [LEN_W-1:0]   y_cnt_q, y_cnt_d;
  logic               overrun_q, overrun_d;
  // Set on the edge an abort is taken so clear_o is seen in the following
  // IDLE cycle, when the state no longer says CLEAR.
  logic               abort_clr_q, abort_clr_d;

  logic x_hs;
  logic y_hs;

  assign x_hs = x_valid_i & x_ready_i;
  assign y_hs = y_valid_i & y_ready_i;

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    shift_d     = shift_q;
    h_cnt_d     = h_cnt_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    overrun_d   = overrun_q;
    abort_clr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          len_d   = len_i;
          shift_d = right_shift_i;
          // A zero-length job has nothing to clear or load.
          state_d = (len_i == '0) ? DONE : CLEAR;
        end
      end

      CLEAR: begin
        h_cnt_d   = '0;
        x_cnt_d   = '0;
        y_cnt_d   = '0;
        overrun_d = 1'b0;
        state_d   = LOAD_H;
      end

      LOAD_H: begin
        if (h_valid_i) begin
          h_cnt_d = h_cnt_q + H_W'(1);
          if (h_cnt_q == H_LAST) begin
            state_d = STREAM;
          end
        end
      end

      STREAM: begin
        // Counters saturate at len; surplus transfers only flag an overrun.
        if (x_hs) begin
          if (x_cnt_q != len_q) begin
            x_cnt_d = x_cnt_q + LEN_W'(1);
          end else begin
            overrun_d = 1'b1;
          end
        end
        if (y_hs) begin
          if (y_cnt_q != len_q) begin
            y_cnt_d = y_cnt_q + LEN_W'(1);
          end else begin
            overrun_d = 1'b1;
          end
        end
        // Compare next-count values so the edge carrying the last y
        // transfer already moves to DONE.
        if ((x_cnt_d == len_q) && (y_cnt_d == len_q)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every other transition, including DONE entry.
    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      abort_clr_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      shift_q     <= '0;
      h_cnt_q     <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      overrun_q   <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      h_cnt_q     <= h_cnt_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      overrun_q   <= overrun_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  // Outputs
  assign h_ready_o     = (state_q == LOAD_H);
  assign x_gate_o      = (state_q == STREAM) && (x_cnt_q != len_q);
  assign clear_o       = (state_q == CLEAR) || abort_clr_q;
  assign busy_o        = (state_q != IDLE);
  // An abort in the DONE cycle suppresses the completion pulse.
  assign done_o        = (state_q == DONE) && !abort_i;
  assign right_shift_o = shift_q;
  assign dbg_state_o   = state_q;

`ifndef SYNTHESIS
  // More x or y transfers than the job length means the surrounding
  // streamers misbehaved.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!overrun_q);
    end
  end
`endif

endmodule
